// File: rtl/minicpu_pkg.sv
// Shared types and constants for the multi-cycle mini CPU: FSM states,
// LoongArch32 subset opcodes and the default reset vector.
package minicpu_pkg;

    typedef enum logic [2:0] {
        IF_REQ,
        IF_WAIT,
        EXE,
        MEM_REQ,
        MEM_WAIT,
        WB,
        HALT
    } state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;

    localparam logic [16:0] OP_ADD_W   = 17'h00020;
    localparam logic [16:0] OP_SUB_W   = 17'h00022;
    localparam logic [9:0]  OP_ADDI_W  = 10'h00a;
    localparam logic [9:0]  OP_LD_W    = 10'h0a2;
    localparam logic [9:0]  OP_ST_W    = 10'h0a6;
    localparam logic [6:0]  OP_LU12I_W = 7'h0a;
    localparam logic [5:0]  OP_BEQ     = 6'h16;
    localparam logic [5:0]  OP_BNE     = 6'h17;

endpackage

// File: rtl/regfile.sv
// 32 x 32 register file: two combinational read ports, one write port on clk.
// r0 always reads as zero; contents are not reset.
module regfile (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] rf [32];

    always_ff @(posedge clk) begin
        if (we) rf[waddr] <= wdata;
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf[raddr2];

endmodule

// File: rtl/minicpu_mc_top.sv
// Multi-cycle LoongArch32-subset core with req/addr_ok/data_ok instruction and
// data ports and a write-back trace port.
module minicpu_mc_top
    import minicpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
    parameter bit          UNKNOWN_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] debug_wb_pc,
    output logic        debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic        halted
);
    state_t      state, state_nxt;
    logic [31:0] pc, ir, result, target, mem_addr, mem_wdata;
    logic [4:0]  wnum;
    logic        wen, taken, is_store;

    logic [4:0]  rd, rj, rk;
    logic [31:0] src_a, src_b, simm12, exe_res, br_target;
    logic        dec_add, dec_sub, dec_addi, dec_ld, dec_st, dec_lu12i, dec_beq, dec_bne;
    logic        dec_known, exe_we, br_taken, wb_we;

    assign rd = ir[4:0];
    assign rj = ir[9:5];
    assign rk = ir[14:10];

    assign dec_add   = ir[31:15] == OP_ADD_W;
    assign dec_sub   = ir[31:15] == OP_SUB_W;
    assign dec_addi  = ir[31:22] == OP_ADDI_W;
    assign dec_ld    = ir[31:22] == OP_LD_W;
    assign dec_st    = ir[31:22] == OP_ST_W;
    assign dec_lu12i = ir[31:25] == OP_LU12I_W;
    assign dec_beq   = ir[31:26] == OP_BEQ;
    assign dec_bne   = ir[31:26] == OP_BNE;
    assign dec_known = dec_add | dec_sub | dec_addi | dec_ld | dec_st |
                       dec_lu12i | dec_beq | dec_bne;

    assign wb_we = (state == WB) && wen;

    // Stores and branches read rd as their second operand instead of rk.
    regfile u_regfile (
        .clk    (clk),
        .raddr1 (rj),
        .rdata1 (src_a),
        .raddr2 ((dec_st | dec_beq | dec_bne) ? rd : rk),
        .rdata2 (src_b),
        .we     (wb_we),
        .waddr  (wnum),
        .wdata  (result)
    );

    assign simm12    = {{20{ir[21]}}, ir[21:10]};
    assign br_target = pc + {{14{ir[25]}}, ir[25:10], 2'b00};
    assign br_taken  = (dec_beq && (src_a == src_b)) || (dec_bne && (src_a != src_b));

    always_comb begin
        exe_res = '0;
        exe_we  = 1'b0;
        if (dec_add) begin
            exe_res = src_a + src_b;
            exe_we  = 1'b1;
        end else if (dec_sub) begin
            exe_res = src_a - src_b;
            exe_we  = 1'b1;
        end else if (dec_addi) begin
            exe_res = src_a + simm12;
            exe_we  = 1'b1;
        end else if (dec_lu12i) begin
            exe_res = {ir[24:5], 12'b0};
            exe_we  = 1'b1;
        end else if (dec_ld) begin
            exe_we  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IF_REQ;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IF_REQ:   if (inst_addr_ok) state_nxt = IF_WAIT;
            IF_WAIT:  if (inst_data_ok) state_nxt = EXE;
            EXE: begin
                if (dec_ld || dec_st)              state_nxt = MEM_REQ;
                else if (!dec_known && UNKNOWN_TRAP) state_nxt = HALT;
                else                               state_nxt = WB;
            end
            MEM_REQ:  if (data_addr_ok) state_nxt = MEM_WAIT;
            MEM_WAIT: if (data_data_ok) state_nxt = WB;
            WB:       state_nxt = IF_REQ;
            HALT:     state_nxt = HALT;
            default:  state_nxt = IF_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc        <= RESET_PC;
            ir        <= '0;
            result    <= '0;
            target    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wnum      <= '0;
            wen       <= 1'b0;
            taken     <= 1'b0;
            is_store  <= 1'b0;
        end else begin
            unique case (state)
                IF_WAIT: if (inst_data_ok) ir <= inst_rdata;
                EXE: begin
                    result    <= exe_res;
                    wen       <= exe_we && (rd != 5'd0);
                    wnum      <= rd;
                    taken     <= br_taken;
                    target    <= br_target;
                    is_store  <= dec_st;
                    mem_addr  <= src_a + simm12;
                    mem_wdata <= src_b;
                end
                MEM_WAIT: if (data_data_ok && !is_store) result <= data_rdata;
                WB:       pc <= taken ? target : pc + 32'd4;
                default: ;
            endcase
        end
    end

    // The reset state is IF_REQ, so the request is masked while reset is held.
    assign inst_req   = resetn && (state == IF_REQ);
    assign inst_addr  = pc;
    assign data_req   = state == MEM_REQ;
    assign data_wr    = data_req && is_store;
    assign data_addr  = data_req ? mem_addr  : '0;
    assign data_wdata = data_req ? mem_wdata : '0;

    assign debug_wb_pc       = (state == WB) ? pc : '0;
    assign debug_wb_rf_we    = wb_we;
    assign debug_wb_rf_wnum  = wb_we ? wnum   : '0;
    assign debug_wb_rf_wdata = wb_we ? result : '0;
    assign halted            = state == HALT;

endmodule

// File: tb/tb_minicpu_mc_top.sv
// Randomized bench for minicpu_mc_top: latency-programmable memory models and
// an instruction-level reference model checked on every retirement.
module tb_minicpu_mc_top;
    localparam logic [31:0] RPC = 32'h1c000000;

    logic clk = 1'b0, resetn = 1'b0;
    always #5 clk = ~clk;

    logic        inst_req, inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
    logic [31:0] inst_addr, inst_rdata = '0;
    logic        data_req, data_wr, data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0] data_addr, data_wdata, data_rdata = '0;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic        debug_wb_rf_we, halted;
    logic [4:0]  debug_wb_rf_wnum;

    minicpu_mc_top #(.RESET_PC(RPC), .UNKNOWN_TRAP(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .halted(halted)
    );

    // Second core with undecoded instructions treated as NOPs, always-ready fetch.
    logic        n_req, n_addr_ok = 1'b0, n_data_ok = 1'b0, n_dreq, n_dwr, n_halted;
    logic [31:0] n_addr, n_rdata = '0, n_daddr, n_dwdata, n_pc, n_wdata;
    logic        n_we;
    logic [4:0]  n_wnum;

    minicpu_mc_top #(.RESET_PC(RPC), .UNKNOWN_TRAP(1'b0)) dut_nop (
        .clk(clk), .resetn(resetn),
        .inst_req(n_req), .inst_addr(n_addr), .inst_addr_ok(n_addr_ok),
        .inst_data_ok(n_data_ok), .inst_rdata(n_rdata),
        .data_req(n_dreq), .data_wr(n_dwr), .data_addr(n_daddr),
        .data_wdata(n_dwdata), .data_addr_ok(1'b0),
        .data_data_ok(1'b0), .data_rdata(32'd0),
        .debug_wb_pc(n_pc), .debug_wb_rf_we(n_we),
        .debug_wb_rf_wnum(n_wnum), .debug_wb_rf_wdata(n_wdata),
        .halted(n_halted)
    );

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- memories ----------------
    logic [31:0] imem [logic [31:0]];
    logic [31:0] dmem [logic [31:0]];
    logic [31:0] mref [logic [31:0]];

    function automatic logic [31:0] imem_rd(input logic [31:0] a);
        return imem.exists(a) ? imem[a] : 32'hffffffff;
    endfunction
    function automatic logic [31:0] dmem_rd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 32'h0;
    endfunction
    function automatic logic [31:0] mref_rd(input logic [31:0] a);
        return mref.exists(a) ? mref[a] : 32'h0;
    endfunction

    int ia = 0, id = 0, da = 0, dd = 0;
    bit rnd = 1'b0;
    function automatic int pick(input int f);
        return rnd ? int'($urandom_range(0, 2)) : f;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int i_cnt = 0, i_lat = 0, cur_ia = 0;
    bit i_pend = 1'b0, i_hold = 1'b0;
    logic [31:0] i_paddr, i_haddr;
    always @(negedge clk) begin
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        if (!resetn) begin
            i_pend = 1'b0; i_hold = 1'b0; i_cnt = 0;
        end else if (i_pend) begin
            if (i_lat == 0) begin
                inst_data_ok = 1'b1; inst_rdata = imem_rd(i_paddr); i_pend = 1'b0;
            end else i_lat--;
        end else if (inst_req) begin
            if (i_cnt == 0) cur_ia = pick(ia);
            if (i_hold) chk("inst_addr_stable", inst_addr, i_haddr);
            if (i_cnt >= cur_ia) begin
                inst_addr_ok = 1'b1; i_pend = 1'b1; i_paddr = inst_addr;
                i_lat = pick(id); i_hold = 1'b0; i_cnt = 0;
            end else begin
                i_cnt++; i_hold = 1'b1; i_haddr = inst_addr;
            end
        end
    end

    int d_cnt = 0, d_lat = 0, cur_da = 0;
    bit d_pend = 1'b0, d_hold = 1'b0, d_isld = 1'b0;
    logic [31:0] d_paddr, d_haddr, d_hwdata;
    logic        d_hwr;
    always @(negedge clk) begin
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        if (!resetn) begin
            d_pend = 1'b0; d_hold = 1'b0; d_cnt = 0;
        end else if (d_pend) begin
            if (d_lat == 0) begin
                data_data_ok = 1'b1; data_rdata = d_isld ? dmem_rd(d_paddr) : 32'h0; d_pend = 1'b0;
            end else d_lat--;
        end else if (data_req) begin
            if (d_cnt == 0) cur_da = pick(da);
            if (d_hold) begin
                chk("data_addr_stable", data_addr, d_haddr);
                chk("data_wdata_stable", data_wdata, d_hwdata);
                chk("data_wr_stable", data_wr, d_hwr);
            end
            if (d_cnt >= cur_da) begin
                data_addr_ok = 1'b1; d_pend = 1'b1; d_paddr = data_addr; d_isld = !data_wr;
                if (data_wr) dmem[data_addr] = data_wdata;
                d_lat = pick(dd); d_hold = 1'b0; d_cnt = 0;
            end else begin
                d_cnt++; d_hold = 1'b1; d_haddr = data_addr; d_hwdata = data_wdata; d_hwr = data_wr;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] mreg [32];
    logic [31:0] trace [32];
    logic [31:0] mpc = RPC, after20 = '0;
    int  fetch_cyc = 0;
    bit  prev_req = 1'b0, chk_next = 1'b0, want20 = 1'b0, got20 = 1'b0;

    function automatic bit is_known(input logic [31:0] ins);
        return ins[31:15] == 17'h00020 || ins[31:15] == 17'h00022 ||
               ins[31:22] == 10'h00a || ins[31:22] == 10'h0a2 || ins[31:22] == 10'h0a6 ||
               ins[31:25] == 7'h0a || ins[31:26] == 6'h16 || ins[31:26] == 6'h17;
    endfunction

    task automatic model_retire();
        logic [31:0] ins, a, b, k, si12, w, npc, boff;
        logic [4:0]  rd, rj, rk;
        bit          we, mem;
        ins = imem_rd(mpc);
        rd = ins[4:0]; rj = ins[9:5]; rk = ins[14:10];
        a = mreg[rj]; b = mreg[rk]; k = mreg[rd];
        si12 = {{20{ins[21]}}, ins[21:10]};
        boff = {{14{ins[25]}}, ins[25:10], 2'b00};
        we = 1'b0; mem = 1'b0; w = '0; npc = mpc + 4;
        if (ins[31:15] == 17'h00020)      begin we = 1'b1; w = a + b; end
        else if (ins[31:15] == 17'h00022) begin we = 1'b1; w = a - b; end
        else if (ins[31:22] == 10'h00a)   begin we = 1'b1; w = a + si12; end
        else if (ins[31:22] == 10'h0a2)   begin we = 1'b1; mem = 1'b1; w = mref_rd(a + si12); end
        else if (ins[31:22] == 10'h0a6)   begin mem = 1'b1; mref[a + si12] = k; end
        else if (ins[31:25] == 7'h0a)     begin we = 1'b1; w = {ins[24:5], 12'h000}; end
        else if (ins[31:26] == 6'h16)     begin if (a == k) npc = mpc + boff; end
        else if (ins[31:26] == 6'h17)     begin if (a != k) npc = mpc + boff; end
        if (rd == 5'd0) we = 1'b0;
        chk("wb_pc", debug_wb_pc, mpc);
        chk("wb_we", debug_wb_rf_we, we);
        if (we) begin
            chk("wb_wnum", debug_wb_rf_wnum, rd);
            chk("wb_wdata", debug_wb_rf_wdata, w);
            mreg[rd] = w;
        end
        if (!rnd) chk("latency", cyc - fetch_cyc + 1, 4 + ia + id + (mem ? 2 + da + dd : 0));
        if (debug_wb_rf_we) trace[debug_wb_rf_wnum] = debug_wb_rf_wdata;
        if (mpc == RPC + 32'h20) want20 = 1'b1;
        mpc = npc; chk_next = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            prev_req = 1'b0; chk_next = 1'b0; want20 = 1'b0; got20 = 1'b0; mpc = RPC;
        end else begin
            if (inst_req && !prev_req) begin
                fetch_cyc = cyc;
                if (chk_next) chk("next_pc", inst_addr, mpc);
                if (want20 && !got20) begin after20 = inst_addr; got20 = 1'b1; end
                chk_next = 1'b0; want20 = 1'b0;
            end
            prev_req = inst_req;
            if (debug_wb_pc != 32'h0) model_retire();
            else chk("dbg_idle", {26'b0, debug_wb_rf_we, debug_wb_rf_wnum} | debug_wb_rf_wdata, 0);
        end
    end

    // NOP-core fetch model and trace capture.
    bit n_pend = 1'b0;
    logic [31:0] n_paddr = '0;
    int n_ret = 0;
    logic [31:0] n_rpc [2];
    logic [31:0] n_rval [2];
    always @(negedge clk) begin
        n_data_ok = n_pend;
        n_rdata = !n_pend ? 32'h0 : (n_paddr == RPC + 4) ? {10'h00a, 12'd9, 5'd0, 5'd6} : 32'hffffffff;
        n_pend = resetn && n_req; n_paddr = n_addr; n_addr_ok = n_pend;
        if (!resetn) n_ret = 0;
        else if (n_pc != 32'h0 && n_ret < 2) begin
            n_rpc[n_ret] = n_pc;
            n_rval[n_ret] = {n_we, 21'b0, n_wnum, 5'b0} ^ n_wdata;
            n_ret++;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] e3r(input logic [16:0] op, input logic [4:0] rd, rj, rk);
        return {op, rk, rj, rd};
    endfunction
    function automatic logic [31:0] ei12(input logic [9:0] op, input logic [4:0] rd, rj, input logic [11:0] si);
        return {op, si, rj, rd};
    endfunction
    function automatic logic [31:0] ebr(input logic [5:0] op, input logic [4:0] rj, rd, input logic [15:0] offs);
        return {op, offs, rj, rd};
    endfunction

    task automatic load_directed(input bit use_beq);
        imem.delete();
        imem[RPC + 32'h00] = ei12(10'h00a, 1, 0, 12'd5);
        imem[RPC + 32'h04] = {7'h0a, 20'h12345, 5'd2};
        imem[RPC + 32'h08] = ei12(10'h00a, 2, 2, 12'h678);
        imem[RPC + 32'h0c] = e3r(17'h00022, 3, 2, 1);
        imem[RPC + 32'h10] = ei12(10'h0a6, 2, 0, 12'h010);
        imem[RPC + 32'h14] = ei12(10'h0a2, 4, 0, 12'h010);
        imem[RPC + 32'h18] = ei12(10'h00a, 1, 1, 12'hfff);
        imem[RPC + 32'h1c] = ei12(10'h00a, 0, 0, 12'd7);
        imem[RPC + 32'h20] = use_beq ? ebr(6'h16, 1, 1, 16'h0004) : ebr(6'h17, 1, 0, 16'hfffe);
        imem[RPC + 32'h24] = e3r(17'h00020, 5, 4, 3);
    endtask

    task automatic gen_random(input int n);
        logic [4:0] r1, r2, r3;
        logic [31:0] w;
        imem.delete();
        for (int r = 1; r < 8; r++) imem[RPC + 4 * (r - 1)] = ei12(10'h00a, r[4:0], 0, 12'($urandom));
        for (int i = 0; i < n; i++) begin
            r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); r3 = 5'($urandom_range(0, 7));
            w = $urandom;
            case ($urandom_range(0, 7))
                0: imem[RPC + 4 * (7 + i)] = e3r(17'h00020, r1, r2, r3);
                1: imem[RPC + 4 * (7 + i)] = e3r(17'h00022, r1, r2, r3);
                2: imem[RPC + 4 * (7 + i)] = ei12(10'h00a, r1, r2, w[11:0]);
                3: imem[RPC + 4 * (7 + i)] = {7'h0a, w[19:0], r1};
                4: imem[RPC + 4 * (7 + i)] = ei12(10'h0a2, r1, r2, w[11:0]);
                5: imem[RPC + 4 * (7 + i)] = ei12(10'h0a6, r1, r2, w[11:0]);
                6: imem[RPC + 4 * (7 + i)] = ebr(6'h16, r2, r1, 16'($urandom_range(1, 3)));
                default: imem[RPC + 4 * (7 + i)] = ebr(6'h17, r2, r1, 16'($urandom_range(1, 3)));
            endcase
        end
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        repeat (n) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 3000) begin @(negedge clk); n++; end
        chk({tag, "_halted"}, halted, 1);
        chk({tag, "_halt_at_undef"}, is_known(imem_rd(mpc)), 0);
        repeat (8) begin
            @(negedge clk);
            chk({tag, "_halt_quiet"}, {29'b0, inst_req, data_req, !halted}, 0);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin mreg[r] = '0; trace[r] = '0; end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst_req", inst_req, 0);
        chk("rst_inst_addr", inst_addr, RPC);
        chk("rst_data_req", {data_req, data_wr}, 0);
        chk("rst_data_addr", data_addr | data_wdata, 0);
        chk("rst_dbg", debug_wb_pc | {31'b0, debug_wb_rf_we}, 0);
        chk("rst_halted", halted, 0);

        // Directed program: bne loop, data_addr_ok stalled 3 cycles.
        load_directed(1'b0);
        ia = 0; id = 0; da = 3; dd = 0; rnd = 1'b0;
        do_reset(2);
        #1;
        chk("first_req", inst_req, 1);
        chk("first_addr", inst_addr, RPC);
        wait_halt("p1");
        chk("p1_r2", trace[2], 32'h12345678);
        chk("p1_r3", trace[3], 32'h12345673);
        chk("p1_r4", trace[4], 32'h12345678);
        chk("p1_r1", trace[1], 32'h0);
        chk("p1_r5", trace[5], 32'h2468aceb);
        chk("p1_bne_target", {31'b0, got20} ^ after20, 32'h1c000019);

        // Reset dropped during a stalled fetch and during IF_WAIT.
        load_directed(1'b1);
        ia = 6; id = 0;
        do_reset(2);
        @(posedge clk); #2;
        chk("req_before_reset", inst_req, 1);
        resetn = 1'b0; #1;
        chk("req_drop_ifreq", inst_req, 0);
        ia = 0; id = 5;
        do_reset(2);
        @(posedge clk); @(posedge clk); #2;
        resetn = 1'b0; #1;
        chk("req_drop_ifwait", inst_req, 0);
        chk("addr_at_reset", inst_addr, RPC);

        // beq at the same pc, mixed fixed delays.
        ia = 1; id = 2; da = 0; dd = 1;
        do_reset(2);
        #1 chk("restart_addr", inst_addr, RPC);
        wait_halt("p2");
        chk("p2_beq_target", {31'b0, got20} ^ after20, 32'h1c000031);

        // Random programs with random handshake delays.
        rnd = 1'b1;
        for (int run = 0; run < 4; run++) begin
            gen_random(40);
            do_reset(3);
            wait_halt("rand");
        end

        // NOP core: undecoded word retires without a write, then pc+4 runs.
        chk("nop_ret_count", n_ret, 2);
        chk("nop_ret0_pc", n_rpc[0], RPC);
        chk("nop_ret0_trace", n_rval[0], 32'h0);
        chk("nop_ret1_pc", n_rpc[1], RPC + 4);
        chk("nop_ret1_trace", n_rval[1], {1'b1, 21'b0, 5'd6, 5'b0} ^ 32'd9);
        chk("nop_not_halted", n_halted, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
